// File: rtl/board_controller.sv
// rtl/board_controller.sv - tic-tac-toe game-state writer for the 3x3 grid
module board_controller #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01,
  parameter logic [3:0] RESTART_KEY  = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [1:0] a9,
  output logic [1:0] current_player,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [8:0] win_line,
  output logic [3:0] move_count,
  output logic       illegal_move
);

  localparam logic [1:0] PLAY  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] OVER  = 2'd2;

  localparam logic [1:0] DRAW  = 2'b11;

  logic [1:0] state;
  logic [1:0] board [9];

  logic [8:0] sel;
  logic [8:0] occupied;
  logic [8:0] win_mask;
  logic       restart;
  logic       place_ok;
  logic       place_bad;

  assign a1 = board[0];
  assign a2 = board[1];
  assign a3 = board[2];
  assign a4 = board[3];
  assign a5 = board[4];
  assign a6 = board[5];
  assign a7 = board[6];
  assign a8 = board[7];
  assign a9 = board[8];

  // Restart wins over everything, including the result of a CHECK cycle.
  assign restart = key_valid && (key_code == RESTART_KEY);

  function automatic logic same3(input logic [1:0] x, input logic [1:0] y, input logic [1:0] z);
    return (x != 2'b00) && (x == y) && (y == z);
  endfunction

  // Decode the key into a one-hot cell select and flag which cells already hold a mark.
  always_comb begin
    sel      = '0;
    occupied = '0;
    for (int i = 0; i < 9; i++) begin
      sel[i]      = (key_code == 4'(i + 1));
      occupied[i] = (board[i] != 2'b00);
    end
  end

  // Only a cell key (1..9) can be placed or rejected; other codes are silently ignored.
  assign place_ok  = key_valid && (|sel) && !(|(sel & occupied));
  assign place_bad = key_valid && (|(sel & occupied));

  // Union of every completed line, so a double win lights both lines.
  always_comb begin
    win_mask = '0;
    if (same3(board[0], board[1], board[2])) win_mask = win_mask | 9'b000000111;
    if (same3(board[3], board[4], board[5])) win_mask = win_mask | 9'b000111000;
    if (same3(board[6], board[7], board[8])) win_mask = win_mask | 9'b111000000;
    if (same3(board[0], board[3], board[6])) win_mask = win_mask | 9'b001001001;
    if (same3(board[1], board[4], board[7])) win_mask = win_mask | 9'b010010010;
    if (same3(board[2], board[5], board[8])) win_mask = win_mask | 9'b100100100;
    if (same3(board[0], board[4], board[8])) win_mask = win_mask | 9'b100010001;
    if (same3(board[2], board[4], board[6])) win_mask = win_mask | 9'b001010100;
  end

  // Game FSM: place a mark in PLAY, judge the board in CHECK, freeze in OVER.
  always_ff @(posedge clock) begin
    if (!reset || restart) begin
      state          <= PLAY;
      for (int i = 0; i < 9; i++) board[i] <= 2'b00;
      current_player <= FIRST_PLAYER;
      winner         <= 2'b00;
      game_over      <= 1'b0;
      win_line       <= '0;
      move_count     <= '0;
      illegal_move   <= 1'b0;
    end else begin
      illegal_move <= 1'b0;
      case (state)
        PLAY: begin
          if (place_ok) begin
            for (int i = 0; i < 9; i++) begin
              if (sel[i]) board[i] <= current_player;
            end
            if (move_count != 4'd9) move_count <= move_count + 4'd1;
            state <= CHECK;
          end else if (place_bad) begin
            illegal_move <= 1'b1;
          end
        end
        CHECK: begin
          if (|win_mask) begin
            winner    <= current_player;
            win_line  <= win_mask;
            game_over <= 1'b1;
            state     <= OVER;
          end else if (move_count == 4'd9) begin
            winner    <= DRAW;
            win_line  <= '0;
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            current_player <= (current_player == 2'b01) ? 2'b10 : 2'b01;
            state          <= PLAY;
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_controller.sv
// tb/tb_board_controller.sv - directed scoreboard bench for board_controller
module tb_board_controller;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [1:0] current_player;
  logic [1:0] winner;
  logic       game_over;
  logic [8:0] win_line;
  logic [3:0] move_count;
  logic       illegal_move;

  board_controller dut (
    .clock          (clock),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .a1             (a1),
    .a2             (a2),
    .a3             (a3),
    .a4             (a4),
    .a5             (a5),
    .a6             (a6),
    .a7             (a7),
    .a8             (a8),
    .a9             (a9),
    .current_player (current_player),
    .winner         (winner),
    .game_over      (game_over),
    .win_line       (win_line),
    .move_count     (move_count),
    .illegal_move   (illegal_move)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [36:0] val;
  } exp_t;

  exp_t sb [$];

  int compared = 0;
  int mismatched = 0;

  logic [1:0] e_board [9];
  logic [1:0] e_cp;
  logic [1:0] e_win;
  logic       e_go;
  logic [8:0] e_line;
  logic [3:0] e_mc;
  logic       e_ill;

  function automatic logic [36:0] observed();
    return {a9, a8, a7, a6, a5, a4, a3, a2, a1,
            current_player, winner, game_over, win_line, move_count, illegal_move};
  endfunction

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.val = {e_board[8], e_board[7], e_board[6], e_board[5], e_board[4],
             e_board[3], e_board[2], e_board[1], e_board[0],
             e_cp, e_win, e_go, e_line, e_mc, e_ill};
    sb.push_back(e);
  endtask

  task automatic exp_reset_state();
    for (int i = 0; i < 9; i++) e_board[i] = 2'b00;
    e_cp   = 2'b01;
    e_win  = 2'b00;
    e_go   = 1'b0;
    e_line = '0;
    e_mc   = '0;
    e_ill  = 1'b0;
  endtask

  // Inputs change on the falling edge; results are checked one falling edge later.
  task automatic cycle(input logic v, input logic [3:0] code, input logic rst_n);
    exp_t e;
    logic [36:0] obs;
    key_valid = v;
    key_code  = code;
    reset     = rst_n;
    @(posedge clock);
    @(negedge clock);
    key_valid = 1'b0;
    key_code  = 4'h0;
    reset     = 1'b1;
    obs = observed();
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
        else begin
          mismatched++;
          $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    end
  endtask

  task automatic move(input logic [3:0] code, input logic [1:0] post_cp,
                      input logic [1:0] post_win, input logic [8:0] post_line, input string tag);
    e_board[int'(code) - 1] = e_cp;
    e_mc  = e_mc + 4'd1;
    e_ill = 1'b0;
    push({tag, "_place"});
    cycle(1'b1, code, 1'b1);
    e_cp   = post_cp;
    e_win  = post_win;
    e_go   = (post_win != 2'b00);
    e_line = post_line;
    push({tag, "_check"});
    cycle(1'b0, 4'h0, 1'b1);
  endtask

  task automatic restart(input string tag);
    exp_reset_state();
    push(tag);
    cycle(1'b1, 4'hA, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    @(negedge clock);

    exp_reset_state();
    push("reset_state");
    cycle(1'b0, 4'h0, 1'b0);

    // Row 1 win for X.
    move(4'd1, 2'b10, 2'b00, 9'b0, "t1_x1");
    move(4'd4, 2'b01, 2'b00, 9'b0, "t1_o4");
    move(4'd2, 2'b10, 2'b00, 9'b0, "t1_x2");
    move(4'd5, 2'b01, 2'b00, 9'b0, "t1_o5");
    move(4'd3, 2'b01, 2'b01, 9'b000000111, "t1_x3_win");

    // Board frozen in OVER, then restart.
    push("t5_over_key6");
    cycle(1'b1, 4'd6, 1'b1);
    push("t5_over_idle");
    cycle(1'b0, 4'h0, 1'b1);
    restart("t5_restart");

    // Occupied cell pulses illegal_move for one cycle only.
    move(4'd5, 2'b10, 2'b00, 9'b0, "t2_x5");
    e_ill = 1'b1;
    push("t2_dup5_pulse");
    cycle(1'b1, 4'd5, 1'b1);
    e_ill = 1'b0;
    push("t2_pulse_gone");
    cycle(1'b0, 4'h0, 1'b1);
    push("t2_code0_ignored");
    cycle(1'b1, 4'h0, 1'b1);
    push("t2_codeB_ignored");
    cycle(1'b1, 4'hB, 1'b1);
    push("t2_codeF_ignored");
    cycle(1'b1, 4'hF, 1'b1);
    restart("t2_restart");

    // Draw with all nine cells filled.
    move(4'd1, 2'b10, 2'b00, 9'b0, "t3_x1");
    move(4'd2, 2'b01, 2'b00, 9'b0, "t3_o2");
    move(4'd3, 2'b10, 2'b00, 9'b0, "t3_x3");
    move(4'd5, 2'b01, 2'b00, 9'b0, "t3_o5");
    move(4'd4, 2'b10, 2'b00, 9'b0, "t3_x4");
    move(4'd6, 2'b01, 2'b00, 9'b0, "t3_o6");
    move(4'd8, 2'b10, 2'b00, 9'b0, "t3_x8");
    move(4'd7, 2'b01, 2'b00, 9'b0, "t3_o7");
    move(4'd9, 2'b01, 2'b11, 9'b0, "t3_x9_draw");
    restart("t3_restart");

    // Key during CHECK is dropped without a pulse.
    e_board[6] = 2'b01;
    e_mc = 4'd1;
    push("t4_place7");
    cycle(1'b1, 4'd7, 1'b1);
    e_cp = 2'b10;
    push("t4_key8_in_check");
    cycle(1'b1, 4'd8, 1'b1);
    push("t4_no_pulse");
    cycle(1'b0, 4'h0, 1'b1);

    // Reset asserted in the CHECK cycle.
    e_board[0] = 2'b10;
    e_mc = 4'd2;
    push("t6_place1");
    cycle(1'b1, 4'd1, 1'b1);
    exp_reset_state();
    push("t6_reset_in_check");
    cycle(1'b0, 4'h0, 1'b0);

    // Restart in the CHECK cycle beats a pending result.
    e_board[1] = 2'b01;
    e_mc = 4'd1;
    push("rc_place2");
    cycle(1'b1, 4'd2, 1'b1);
    restart("rc_restart_in_check");

    // Ninth move completes both diagonals: win beats draw, lines ORed.
    move(4'd1, 2'b10, 2'b00, 9'b0, "dd_x1");
    move(4'd2, 2'b01, 2'b00, 9'b0, "dd_o2");
    move(4'd3, 2'b10, 2'b00, 9'b0, "dd_x3");
    move(4'd4, 2'b01, 2'b00, 9'b0, "dd_o4");
    move(4'd7, 2'b10, 2'b00, 9'b0, "dd_x7");
    move(4'd6, 2'b01, 2'b00, 9'b0, "dd_o6");
    move(4'd9, 2'b10, 2'b00, 9'b0, "dd_x9");
    move(4'd8, 2'b01, 2'b00, 9'b0, "dd_o8");
    move(4'd5, 2'b01, 2'b01, 9'b101010101, "dd_x5_double");
    restart("dd_restart");

    compared++;
    assert (sb.size() == 0)
      else begin
        mismatched++;
        $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
